// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, simultaneous push/pop at any occupancy
// ports: clk_i, rst_ni (async active-low), flush_i, push_i/data_i, pop_i/data_o (head), count_o
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  assign w_pop   = pop_i & (r_cnt != '0);
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push  = push_i & ((r_cnt != FULL) | w_pop);
  assign data_o  = r_mem[r_rd];
  assign count_o = r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order imem requests, buffers {pc,instr} for decode
// ports: imem_req_* request handshake, imem_rsp_* in-order responses, redirect_* flush/restart,
//        id_* decode handshake with instruction, its pc and pc+4
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_inflight;
  logic [CW-1:0] w_count;
  logic [31:0]  w_rsp_pc;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;
  logic         w_req_fire;
  logic         w_keep;
  logic         w_pop;
  // credit rule: every outstanding request already owns a buffer slot
  assign imem_req_valid_o = (r_state == RUN) & ~redirect_i &
                            (({1'b0, w_inflight} + {1'b0, w_count}) < (CW+1)'(DEPTH));
  assign imem_req_addr_o  = r_pc;
  assign w_req_fire       = imem_req_valid_o & imem_req_ready_i;
  assign w_keep           = imem_rsp_valid_i & ~redirect_i & (r_drop == '0);
  assign w_entry          = '{pc: w_rsp_pc, instr: imem_rsp_data_i};
  assign id_valid_o       = w_count != '0;
  assign w_pop            = id_valid_o & id_ready_i;
  assign id_instr_o       = id_valid_o ? w_head.instr : NOP_INSTR;
  assign id_pc_o          = id_valid_o ? w_head.pc : 32'h0;
  assign id_pc4_o         = id_pc_o + 32'd4;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_drop  <= '0;
    end else begin
      r_state <= RUN;
      if (redirect_i) begin
        r_pc   <= redirect_pc_i & ~32'h3;
        // everything still outstanding after this cycle's response is stale
        r_drop <= w_inflight - CW'(imem_rsp_valid_i);
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (imem_rsp_valid_i && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
    end
  end
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pcq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (w_req_fire),
    .data_i  (r_pc),
    .pop_i   (imem_rsp_valid_i),
    .data_o  (w_rsp_pc),
    .count_o (w_inflight)
  );
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (w_keep),
    .data_i  (w_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table, corner sequences and random traffic against an epoch-based model
module tb_fetch_stage;
  import fetch_pkg::*;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_pc4_o         (id_pc4_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {bit rdy; bit idr; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;} vec_t;
  req_t        mq[$];
  ent_t        bq[$];
  logic [31:0] m_pc;
  int          m_epoch;
  bit          m_boot;
  int          cyc;
  int          vectors = 0;
  int          miscompares = 0;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;
  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid_o}, 32'd0);
    check({tag, "_req_addr"}, imem_req_addr_o, RESET_PC);
    check({tag, "_id_valid"}, {31'b0, id_valid_o}, 32'd0);
    check({tag, "_id_instr"}, id_instr_o, NOP_INSTR);
    check({tag, "_id_pc"}, id_pc_o, 32'h0);
    check({tag, "_id_pc4"}, id_pc4_o, 32'h4);
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    #1;
    reset_checks("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mq.delete();
    bq.delete();
    m_pc = RESET_PC;
    m_epoch = 0;
    m_boot = 1'b1;
    cyc = 0;
  endtask
  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc, input int lat);
    bit   rsp;
    bit   e_rv;
    req_t h;
    rsp = 1'b0;
    if (mq.size() > 0) rsp = mq[0].due <= cyc;
    imem_req_ready_i = rdy;
    id_ready_i = idr;
    redirect_i = redir;
    redirect_pc_i = rpc;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i = $urandom;
    if (rsp) imem_rsp_data_i = word_at(mq[0].addr);
    @(negedge clk);
    s_rv = imem_req_valid_o; s_addr = imem_req_addr_o; s_iv = id_valid_o;
    s_instr = id_instr_o; s_pc = id_pc_o; s_pc4 = id_pc4_o;
    e_rv = !m_boot && !redir && (mq.size() + bq.size() < DEPTH);
    check("req_valid", {31'b0, s_rv}, {31'b0, e_rv});
    check("req_addr", s_addr, m_pc);
    check("id_valid", {31'b0, s_iv}, {31'b0, bq.size() != 0});
    check("id_instr", s_instr, bq.size() != 0 ? bq[0].instr : NOP_INSTR);
    if (bq.size() != 0) begin
      check("id_pc", s_pc, bq[0].pc);
      check("id_pc4", s_pc4, bq[0].pc + 32'd4);
    end
    if (bq.size() != 0 && idr) void'(bq.pop_front());
    if (rsp) begin
      h = mq.pop_front();
      if (!redir && h.epoch == m_epoch) bq.push_back('{h.addr, word_at(h.addr)});
    end
    if (redir) begin
      bq.delete();
      m_epoch++;
      m_pc = rpc & ~32'h3;
    end else if (e_rv && rdy) begin
      mq.push_back('{m_pc, m_epoch, cyc + lat});
      m_pc += 32'd4;
    end
    m_boot = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[7];
    int   fires;
    bit   got, seen_hi;
    int   stage;
    tbl[0] = '{1, 1, 0, 32'h00, 0, 32'h0};
    tbl[1] = '{1, 1, 1, 32'h00, 0, 32'h0};
    tbl[2] = '{1, 1, 1, 32'h04, 0, 32'h0};
    tbl[3] = '{1, 1, 0, 32'h08, 1, 32'h0};
    tbl[4] = '{1, 1, 1, 32'h08, 1, 32'h4};
    tbl[5] = '{1, 1, 1, 32'h0C, 0, 32'h0};
    tbl[6] = '{1, 1, 0, 32'h10, 1, 32'h8};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rdy, tbl[i].idr, 1'b0, 32'h0, 1);
      check("tbl_req_valid", {31'b0, s_rv}, {31'b0, tbl[i].rv});
      check("tbl_req_addr", s_addr, tbl[i].addr);
      check("tbl_id_valid", {31'b0, s_iv}, {31'b0, tbl[i].iv});
      if (tbl[i].iv) check("tbl_id_pc", s_pc, tbl[i].pc);
    end
    do_reset();
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1);
      if (s_rv) fires++;
    end
    check("bp_req_count", fires, 2);
    check("bp_stalled", {31'b0, s_rv}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("bp_first_pc", s_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("bp_second_pc", s_pc, 32'h4);
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 4);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 4);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 4);
      if (s_rv) begin check("redir_req_addr", s_addr, 32'h0000_0100); got = 1'b1; end
    end
    check("redir_req_seen", {31'b0, got}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 4);
      if (s_iv) begin check("redir_first_pc", s_pc, 32'h0000_0100); got = 1'b1; end
    end
    check("redir_id_seen", {31'b0, got}, 32'd1);
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
    check("rc_pop_valid", {31'b0, s_iv}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("rc_flushed", {31'b0, s_iv}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_iv) begin check("rc_first_pc", s_pc, 32'h0000_0200); got = 1'b1; end
    end
    check("rc_id_seen", {31'b0, got}, 32'd1);
    do_reset();
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1);
    got = 1'b0;
    seen_hi = 1'b0;
    stage = 0;
    for (int i = 0; i < 30 && !(got && stage == 2); i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_rv && stage == 1) begin check("wrap_next_addr", s_addr, 32'h0); stage = 2; end
      if (s_rv && stage == 0) begin check("wrap_hi_addr", s_addr, 32'hFFFF_FFFC); stage = 1; end
      if (s_iv && s_pc == 32'hFFFF_FFFC) begin check("wrap_pc4", s_pc4, 32'h0); got = 1'b1; end
    end
    check("wrap_entry_seen", {31'b0, got}, 32'd1);
    check("wrap_stage", stage, 2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    reset_checks("async");
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_rv) begin check("restart_addr", s_addr, RESET_PC); got = 1'b1; end
    end
    check("restart_seen", {31'b0, got}, 32'd1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           rpc, $urandom_range(1, 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
